// File: rtl/control_unit_pkg.sv
// control_unit_pkg: shared definitions for the ALUSystem hardwired sequencer.
//   - FSM state codes (also exported on State_Dbg)
//   - opcode, ALU, register-file and mux select codes
//   - the packed control vector and its idle default
package control_unit_pkg;

   localparam int unsigned ADDR_W   = 8;
   localparam int unsigned OPC_W    = 4;
   localparam logic [OPC_W-1:0] HALT_OPC = 4'hF;

   typedef enum logic [2:0] {
      StInit   = 3'd0,
      StFetchH = 3'd1,
      StFetchL = 3'd2,
      StEx1    = 3'd3,
      StEx2    = 3'd4,
      StHalt   = 3'd5
   } state_e;

   // Opcodes, IR[15:12]
   localparam logic [3:0] OPC_LDI = 4'h0;
   localparam logic [3:0] OPC_LDM = 4'h1;
   localparam logic [3:0] OPC_STM = 4'h2;
   localparam logic [3:0] OPC_MOV = 4'h3;
   localparam logic [3:0] OPC_ADD = 4'h4;
   localparam logic [3:0] OPC_SUB = 4'h5;
   localparam logic [3:0] OPC_AND = 4'h6;
   localparam logic [3:0] OPC_OR  = 4'h7;
   localparam logic [3:0] OPC_XOR = 4'h8;
   localparam logic [3:0] OPC_NOT = 4'h9;
   localparam logic [3:0] OPC_LSL = 4'hA;
   localparam logic [3:0] OPC_LSR = 4'hB;
   localparam logic [3:0] OPC_INC = 4'hC;
   localparam logic [3:0] OPC_DEC = 4'hD;
   localparam logic [3:0] OPC_BR  = 4'hE;

   // ALU_FunSel codes
   localparam logic [3:0] ALU_PASS_A = 4'b0000;
   localparam logic [3:0] ALU_NOT_A  = 4'b0010;
   localparam logic [3:0] ALU_ADD    = 4'b0100;
   localparam logic [3:0] ALU_SUB    = 4'b0110;
   localparam logic [3:0] ALU_AND    = 4'b0111;
   localparam logic [3:0] ALU_OR     = 4'b1000;
   localparam logic [3:0] ALU_XOR    = 4'b1001;
   localparam logic [3:0] ALU_LSL    = 4'b1010;
   localparam logic [3:0] ALU_LSR    = 4'b1011;

   // RF / ARF / IR FunSel codes
   localparam logic [1:0] FUN_DEC  = 2'b00;
   localparam logic [1:0] FUN_INC  = 2'b01;
   localparam logic [1:0] FUN_LOAD = 2'b10;
   localparam logic [1:0] FUN_CLR  = 2'b11;

   // Mux and address-register select codes
   localparam logic [1:0] MUXA_IMM   = 2'b00;
   localparam logic [1:0] MUXA_MEM   = 2'b01;
   localparam logic [1:0] MUXA_ALU   = 2'b11;
   localparam logic [1:0] MUXB_IMM   = 2'b01;
   localparam logic       MUXC_RF_A  = 1'b1;
   localparam logic [1:0] ARF_OUT_PC = 2'b00;
   localparam logic [1:0] ARF_OUT_AR = 2'b10;

   // ARF_RegSel is active-low: [0] PC, [1] AR, [2] SP
   localparam logic [2:0] ARF_EN_NONE = 3'b111;
   localparam logic [2:0] ARF_EN_ALL  = 3'b000;
   localparam logic [2:0] ARF_EN_PC   = 3'b110;
   localparam logic [2:0] ARF_EN_AR   = 3'b101;

   typedef struct packed {
      logic [1:0] rf_out_a_sel;
      logic [1:0] rf_out_b_sel;
      logic [1:0] rf_fun_sel;
      logic [3:0] rf_reg_sel;
      logic [3:0] alu_fun_sel;
      logic [1:0] arf_out_c_sel;
      logic [1:0] arf_out_d_sel;
      logic [1:0] arf_fun_sel;
      logic [2:0] arf_reg_sel;
      logic       ir_lh;
      logic       ir_enable;
      logic [1:0] ir_funsel;
      logic       mem_wr;
      logic       mem_cs;
      logic [1:0] mux_a_sel;
      logic [1:0] mux_b_sel;
      logic       mux_c_sel;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '{
      rf_out_a_sel:  2'b00,
      rf_out_b_sel:  2'b00,
      rf_fun_sel:    2'b00,
      rf_reg_sel:    4'hF,
      alu_fun_sel:   4'h0,
      arf_out_c_sel: 2'b00,
      arf_out_d_sel: 2'b00,
      arf_fun_sel:   2'b00,
      arf_reg_sel:   ARF_EN_NONE,
      ir_lh:         1'b0,
      ir_enable:     1'b0,
      ir_funsel:     2'b00,
      mem_wr:        1'b0,
      mem_cs:        1'b1,
      mux_a_sel:     2'b00,
      mux_b_sel:     2'b00,
      mux_c_sel:     1'b0
   };

   // Register-file output select for R(n+1)
   function automatic logic [1:0] rf_out_sel(input logic [1:0] n);
      return ~n;
   endfunction

   // Active-low register-file write enable for R(n+1)
   function automatic logic [3:0] rf_reg_en(input logic [1:0] n);
      return ~(4'b0001 << n);
   endfunction

endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: bundle between the sequencer and ALUSystem.
//   master: the control unit (drives selects/enables, receives IR_Q and Z_Flag)
//   slave : the datapath side (or a testbench standing in for it)
interface control_unit_if;

   logic [15:0] IR_Q;
   logic        Z_Flag;
   logic [1:0]  RF_OutASel;
   logic [1:0]  RF_OutBSel;
   logic [1:0]  RF_FunSel;
   logic [3:0]  RF_RegSel;
   logic [3:0]  ALU_FunSel;
   logic [1:0]  ARF_OutCSel;
   logic [1:0]  ARF_OutDSel;
   logic [1:0]  ARF_FunSel;
   logic [2:0]  ARF_RegSel;
   logic        IR_LH;
   logic        IR_Enable;
   logic [1:0]  IR_Funsel;
   logic        Mem_WR;
   logic        Mem_CS;
   logic [1:0]  MuxASel;
   logic [1:0]  MuxBSel;
   logic        MuxCSel;
   logic        Halted;
   logic [2:0]  State_Dbg;

   modport master (
      input  IR_Q, Z_Flag,
      output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel,
             ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
             IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
             MuxASel, MuxBSel, MuxCSel, Halted, State_Dbg
   );

   modport slave (
      output IR_Q, Z_Flag,
      input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel,
             ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
             IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
             MuxASel, MuxBSel, MuxCSel, Halted, State_Dbg
   );

endinterface

// File: rtl/control_unit_decoder.sv
// control_unit_decoder: purely combinational decode of (state, IR[15:8], z) into the
// ALUSystem control vector.
//   i_state  current sequencer state
//   i_ir_hi  IR[15:8]: opcode, Rx, Ry/branch condition (imm reaches the datapath directly)
//   i_z      registered Z flag for conditional branches
//   o_ctrl   control vector, idle defaults unless the state/opcode drives a field
module control_unit_decoder
   import control_unit_pkg::*;
(
   input  state_e     i_state,
   input  logic [7:0] i_ir_hi,
   input  logic       i_z,
   output ctrl_t      o_ctrl
);

   logic [3:0] w_opc;
   logic [1:0] w_rx;
   logic [1:0] w_ry;
   logic       w_br_taken;

   assign w_opc = i_ir_hi[7:4];
   assign w_rx  = i_ir_hi[3:2];
   assign w_ry  = i_ir_hi[1:0];

   always_comb begin
      w_br_taken = 1'b0;
      unique case (w_ry)
         2'b00:   w_br_taken = 1'b1;
         2'b01:   w_br_taken = i_z;
         2'b10:   w_br_taken = ~i_z;
         default: w_br_taken = 1'b0;   // cond 11 is a NOP
      endcase
   end

   always_comb begin
      o_ctrl = CTRL_IDLE;
      unique case (i_state)
         StInit: begin
            o_ctrl.rf_reg_sel  = 4'h0;
            o_ctrl.rf_fun_sel  = FUN_CLR;
            o_ctrl.arf_reg_sel = ARF_EN_ALL;
            o_ctrl.arf_fun_sel = FUN_CLR;
            o_ctrl.ir_enable   = 1'b1;
            o_ctrl.ir_funsel   = FUN_CLR;
         end
         StFetchH, StFetchL: begin
            o_ctrl.arf_out_d_sel = ARF_OUT_PC;
            o_ctrl.mem_cs        = 1'b0;
            o_ctrl.ir_enable     = 1'b1;
            o_ctrl.ir_funsel     = FUN_LOAD;
            o_ctrl.ir_lh         = (i_state == StFetchL);
            o_ctrl.arf_reg_sel   = ARF_EN_PC;
            o_ctrl.arf_fun_sel   = FUN_INC;
         end
         StEx1: begin
            case (w_opc)
               OPC_LDI: begin
                  o_ctrl.mux_a_sel  = MUXA_IMM;
                  o_ctrl.rf_reg_sel = rf_reg_en(w_rx);
                  o_ctrl.rf_fun_sel = FUN_LOAD;
               end
               OPC_LDM, OPC_STM: begin
                  o_ctrl.mux_b_sel   = MUXB_IMM;
                  o_ctrl.arf_reg_sel = ARF_EN_AR;
                  o_ctrl.arf_fun_sel = FUN_LOAD;
               end
               OPC_MOV, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR,
               OPC_NOT, OPC_LSL, OPC_LSR: begin
                  o_ctrl.mux_c_sel    = MUXC_RF_A;
                  o_ctrl.mux_a_sel    = MUXA_ALU;
                  o_ctrl.rf_reg_sel   = rf_reg_en(w_rx);
                  o_ctrl.rf_fun_sel   = FUN_LOAD;
                  o_ctrl.rf_out_a_sel = rf_out_sel(w_rx);
                  case (w_opc)
                     OPC_MOV: begin
                        o_ctrl.rf_out_a_sel = rf_out_sel(w_ry);
                        o_ctrl.alu_fun_sel  = ALU_PASS_A;
                     end
                     OPC_ADD: o_ctrl.alu_fun_sel = ALU_ADD;
                     OPC_SUB: o_ctrl.alu_fun_sel = ALU_SUB;
                     OPC_AND: o_ctrl.alu_fun_sel = ALU_AND;
                     OPC_OR:  o_ctrl.alu_fun_sel = ALU_OR;
                     OPC_XOR: o_ctrl.alu_fun_sel = ALU_XOR;
                     OPC_NOT: o_ctrl.alu_fun_sel = ALU_NOT_A;
                     OPC_LSL: o_ctrl.alu_fun_sel = ALU_LSL;
                     default: o_ctrl.alu_fun_sel = ALU_LSR;
                  endcase
                  // Two-operand ops take Ry on the B side
                  if (w_opc >= OPC_ADD && w_opc <= OPC_XOR) begin
                     o_ctrl.rf_out_b_sel = rf_out_sel(w_ry);
                  end
               end
               OPC_INC, OPC_DEC: begin
                  o_ctrl.rf_reg_sel = rf_reg_en(w_rx);
                  o_ctrl.rf_fun_sel = (w_opc == OPC_INC) ? FUN_INC : FUN_DEC;
               end
               OPC_BR: begin
                  if (w_br_taken) begin
                     o_ctrl.mux_b_sel   = MUXB_IMM;
                     o_ctrl.arf_reg_sel = ARF_EN_PC;
                     o_ctrl.arf_fun_sel = FUN_LOAD;
                  end
               end
               default: ;   // HLT: idle while moving to HALT
            endcase
         end
         StEx2: begin
            if (w_opc == OPC_LDM) begin
               o_ctrl.arf_out_d_sel = ARF_OUT_AR;
               o_ctrl.mem_cs        = 1'b0;
               o_ctrl.mux_a_sel     = MUXA_MEM;
               o_ctrl.rf_reg_sel    = rf_reg_en(w_rx);
               o_ctrl.rf_fun_sel    = FUN_LOAD;
            end else if (w_opc == OPC_STM) begin
               o_ctrl.rf_out_a_sel  = rf_out_sel(w_rx);
               o_ctrl.mux_c_sel     = MUXC_RF_A;
               o_ctrl.alu_fun_sel   = ALU_PASS_A;
               o_ctrl.arf_out_d_sel = ARF_OUT_AR;
               o_ctrl.mem_cs        = 1'b0;
               o_ctrl.mem_wr        = 1'b1;
            end
         end
         default: ;   // HALT: idle
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired sequencer for ALUSystem. Fetches a 16-bit instruction into IR
// (high byte first), then executes it in one or two cycles.
//   Clock  system clock, state changes on posedge
//   Reset  synchronous, active-high; forces idle outputs and returns to INIT
//   bus    control_unit_if master: IR_Q/Z_Flag in, all ALUSystem selects/enables out,
//          plus Halted and State_Dbg
module control_unit
   import control_unit_pkg::*;
(
   input  logic            Clock,
   input  logic            Reset,
   control_unit_if.master  bus
);

   state_e r_state;
   state_e w_state_next;
   logic   r_z;
   logic   w_z_next;
   ctrl_t  w_dec;
   ctrl_t  w_ctrl;
   logic [3:0] w_opc;

   assign w_opc = bus.IR_Q[15:12];

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state <= StInit;
         r_z     <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_z     <= w_z_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_z_next     = r_z;
      unique case (r_state)
         StInit: begin
            w_state_next = StFetchH;
            w_z_next     = 1'b0;
         end
         StFetchH: w_state_next = StFetchL;
         StFetchL: w_state_next = StEx1;
         StEx1: begin
            // Only ALU data ops update the flag; moves, loads and branches keep it
            if (w_opc >= OPC_ADD && w_opc <= OPC_LSR) begin
               w_z_next = bus.Z_Flag;
            end
            if (w_opc == HALT_OPC) begin
               w_state_next = StHalt;
            end else if (w_opc == OPC_LDM || w_opc == OPC_STM) begin
               w_state_next = StEx2;
            end else begin
               w_state_next = StFetchH;
            end
         end
         StEx2:   w_state_next = StFetchH;
         default: w_state_next = StHalt;
      endcase
   end

   control_unit_decoder u_decoder (
      .i_state (r_state),
      .i_ir_hi (bus.IR_Q[15:8]),
      .i_z     (r_z),
      .o_ctrl  (w_dec)
   );

   // Gating on Reset keeps an in-flight write from reaching memory on the reset edge
   assign w_ctrl = Reset ? CTRL_IDLE : w_dec;

   assign bus.RF_OutASel  = w_ctrl.rf_out_a_sel;
   assign bus.RF_OutBSel  = w_ctrl.rf_out_b_sel;
   assign bus.RF_FunSel   = w_ctrl.rf_fun_sel;
   assign bus.RF_RegSel   = w_ctrl.rf_reg_sel;
   assign bus.ALU_FunSel  = w_ctrl.alu_fun_sel;
   assign bus.ARF_OutCSel = w_ctrl.arf_out_c_sel;
   assign bus.ARF_OutDSel = w_ctrl.arf_out_d_sel;
   assign bus.ARF_FunSel  = w_ctrl.arf_fun_sel;
   assign bus.ARF_RegSel  = w_ctrl.arf_reg_sel;
   assign bus.IR_LH       = w_ctrl.ir_lh;
   assign bus.IR_Enable   = w_ctrl.ir_enable;
   assign bus.IR_Funsel   = w_ctrl.ir_funsel;
   assign bus.Mem_WR      = w_ctrl.mem_wr;
   assign bus.Mem_CS      = w_ctrl.mem_cs;
   assign bus.MuxASel     = w_ctrl.mux_a_sel;
   assign bus.MuxBSel     = w_ctrl.mux_b_sel;
   assign bus.MuxCSel     = w_ctrl.mux_c_sel;
   assign bus.Halted      = (r_state == StHalt) && !Reset;
   assign bus.State_Dbg   = r_state;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: random instruction stream against an instruction-level model of what the
// sequencer must drive each cycle (fetch/execute timing, per-opcode register effects, Z flag,
// branch conditions, halt, synchronous reset at random points including STM's write cycle).
module tb_control_unit;

   typedef enum int {PRst, PInit, PFh, PFl, PE1, PE2, PHalt} phase_t;

   typedef struct packed {
      logic [1:0] out_a;
      logic [1:0] out_b;
      logic [1:0] rf_fun;
      logic [3:0] rf_en;
      logic [3:0] alu;
      logic [1:0] arf_c;
      logic [1:0] arf_d;
      logic [1:0] arf_fun;
      logic [2:0] arf_en;
      logic       ir_lh;
      logic       ir_en;
      logic [1:0] ir_fun;
      logic       mem_wr;
      logic       mem_cs;
      logic [1:0] mux_a;
      logic [1:0] mux_b;
      logic       mux_c;
   } exp_t;

   logic Clock;
   logic Reset;
   control_unit_if bus_if ();

   control_unit dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus_if)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // ALU code each opcode must request (only meaningful for 3..B)
   logic [3:0] alu_of [16] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h6, 4'h7, 4'h8,
                               4'h9, 4'h2, 4'hA, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0};

   int n_total = 0;
   int n_bad   = 0;

   phase_t      m_phase;
   logic        m_z;
   logic [15:0] m_instr;
   int          halt_cnt;
   int          n_halts;
   int          n_stm_resets;

   function automatic logic [1:0] sel_of(input int n);
      return 2'(3 - n);
   endfunction

   function automatic logic [3:0] en_of(input int n);
      return 4'(15 - (1 << n));
   endfunction

   function automatic exp_t model_ctrl(input phase_t ph, input logic [15:0] ir, input logic z);
      exp_t c;
      int   op;
      int   rx;
      int   ry;
      bit   taken;
      c        = '0;
      c.rf_en  = 4'hF;
      c.arf_en = 3'h7;
      c.mem_cs = 1'b1;
      op = int'(ir[15:12]);
      rx = int'(ir[11:10]);
      ry = int'(ir[9:8]);
      case (ph)
         PInit: begin
            c.rf_en = 4'h0;  c.rf_fun  = 2'd3;
            c.arf_en = 3'h0; c.arf_fun = 2'd3;
            c.ir_en = 1'b1;  c.ir_fun  = 2'd3;
         end
         PFh, PFl: begin
            c.arf_d = 2'd0;  c.mem_cs = 1'b0;
            c.ir_en = 1'b1;  c.ir_fun = 2'd2; c.ir_lh = (ph == PFl);
            c.arf_en = 3'b110; c.arf_fun = 2'd1;
         end
         PE1: begin
            if (op == 0) begin
               c.mux_a = 2'd0; c.rf_en = en_of(rx); c.rf_fun = 2'd2;
            end else if (op == 1 || op == 2) begin
               c.mux_b = 2'd1; c.arf_en = 3'b101; c.arf_fun = 2'd2;
            end else if (op >= 3 && op <= 11) begin
               c.mux_c = 1'b1; c.mux_a = 2'd3; c.alu = alu_of[op];
               c.rf_en = en_of(rx); c.rf_fun = 2'd2;
               c.out_a = (op == 3) ? sel_of(ry) : sel_of(rx);
               if (op >= 4 && op <= 8) c.out_b = sel_of(ry);
            end else if (op == 12 || op == 13) begin
               c.rf_en = en_of(rx); c.rf_fun = (op == 12) ? 2'd1 : 2'd0;
            end else if (op == 14) begin
               taken = (ry == 0) || (ry == 1 && z) || (ry == 2 && !z);
               if (taken) begin
                  c.mux_b = 2'd1; c.arf_en = 3'b110; c.arf_fun = 2'd2;
               end
            end
         end
         PE2: begin
            if (op == 1) begin
               c.arf_d = 2'd2; c.mem_cs = 1'b0; c.mux_a = 2'd1;
               c.rf_en = en_of(rx); c.rf_fun = 2'd2;
            end else if (op == 2) begin
               c.out_a = sel_of(rx); c.mux_c = 1'b1; c.alu = 4'h0;
               c.arf_d = 2'd2; c.mem_cs = 1'b0; c.mem_wr = 1'b1;
            end
         end
         default: ;
      endcase
      return c;
   endfunction

   function automatic logic [2:0] code_of(input phase_t ph);
      case (ph)
         PInit:   return 3'd0;
         PFh:     return 3'd1;
         PFl:     return 3'd2;
         PE1:     return 3'd3;
         PE2:     return 3'd4;
         default: return 3'd5;
      endcase
   endfunction

   initial begin
      exp_t obs;
      exp_t exp_c;
      int   r;
      Reset          = 1'b1;
      bus_if.IR_Q    = 16'h0000;
      bus_if.Z_Flag  = 1'b0;
      m_phase        = PRst;
      m_z            = 1'b0;
      m_instr        = 16'h0000;
      halt_cnt       = 0;
      n_halts        = 0;
      n_stm_resets   = 0;
      #1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         // Drive this cycle's inputs
         if (cyc < 2) begin
            Reset = 1'b1;
         end else if (m_phase == PHalt) begin
            halt_cnt++;
            Reset = (halt_cnt > 4);
         end else if (m_phase == PE2 && m_instr[15:12] == 4'h2) begin
            Reset = ($urandom_range(0, 3) == 0);
            if (Reset) n_stm_resets++;
         end else begin
            Reset = ($urandom_range(0, 79) == 0);
         end
         bus_if.IR_Q   = (m_phase == PE1 || m_phase == PE2) ? m_instr : 16'($urandom);
         bus_if.Z_Flag = 1'($urandom);

         @(negedge Clock);
         exp_c = Reset ? model_ctrl(PRst, 16'h0, 1'b0) : model_ctrl(m_phase, bus_if.IR_Q, m_z);
         obs = {bus_if.RF_OutASel, bus_if.RF_OutBSel, bus_if.RF_FunSel, bus_if.RF_RegSel,
                bus_if.ALU_FunSel, bus_if.ARF_OutCSel, bus_if.ARF_OutDSel, bus_if.ARF_FunSel,
                bus_if.ARF_RegSel, bus_if.IR_LH, bus_if.IR_Enable, bus_if.IR_Funsel,
                bus_if.Mem_WR, bus_if.Mem_CS, bus_if.MuxASel, bus_if.MuxBSel, bus_if.MuxCSel};
         n_total++;
         assert (obs === exp_c) else begin
            n_bad++;
            $error("FAIL ctrl cyc=%0d ph=%0d ir=%h rst=%0b got=%h exp=%h",
                   cyc, m_phase, bus_if.IR_Q, Reset, obs, exp_c);
         end
         n_total++;
         assert (bus_if.Halted === (m_phase == PHalt && !Reset)) else begin
            n_bad++;
            $error("FAIL halted cyc=%0d got=%b exp=%b", cyc, bus_if.Halted,
                   (m_phase == PHalt && !Reset));
         end
         if (m_phase != PRst) begin
            n_total++;
            assert (bus_if.State_Dbg === code_of(m_phase)) else begin
               n_bad++;
               $error("FAIL state cyc=%0d got=%0d exp=%0d", cyc, bus_if.State_Dbg,
                      code_of(m_phase));
            end
         end

         // Advance the model across the clock edge
         @(posedge Clock);
         if (Reset) begin
            m_phase  = PInit;
            m_z      = 1'b0;
            halt_cnt = 0;
         end else begin
            case (m_phase)
               PInit: begin
                  m_z     = 1'b0;
                  m_phase = PFh;
               end
               PFh: m_phase = PFl;
               PFl: m_phase = PE1;
               PE1: begin
                  if (m_instr[15:12] >= 4'h4 && m_instr[15:12] <= 4'hB) m_z = bus_if.Z_Flag;
                  if (m_instr[15:12] == 4'hF) begin
                     m_phase = PHalt;
                     n_halts++;
                  end else if (m_instr[15:12] == 4'h1 || m_instr[15:12] == 4'h2) begin
                     m_phase = PE2;
                  end else begin
                     m_phase = PFh;
                  end
               end
               PE2:     m_phase = PFh;
               default: m_phase = m_phase;
            endcase
         end
         if (m_phase == PFh) begin
            r       = int'($urandom_range(0, 31));
            m_instr = {((r < 30) ? 4'(r % 15) : 4'hF), 12'($urandom)};
         end
         #1;
      end
      // The stream must actually have reached the halt and STM-reset corners
      n_total++;
      assert (n_halts > 0 && n_stm_resets > 0) else begin
         n_bad++;
         $error("FAIL coverage halts=%0d stm_resets=%0d required both >0", n_halts,
                n_stm_resets);
      end
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
